// File: rtl/sccb_target_regfile.sv
// rtl/sccb_target_regfile.sv - SCCB/I2C target with a 256 x 8 register file
`timescale 1ns/1ps
module sccb_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEVADDR   = 4'd1;
    localparam logic [3:0] S_ACK_DEV   = 4'd2;
    localparam logic [3:0] S_REGADDR   = 4'd3;
    localparam logic [3:0] S_ACK_REG   = 4'd4;
    localparam logic [3:0] S_WRDATA    = 4'd5;
    localparam logic [3:0] S_ACK_WR    = 4'd6;
    localparam logic [3:0] S_RDDATA    = 4'd7;
    localparam logic [3:0] S_RD_MACK   = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    logic scl_m_q, scl_s_q, scl_h_q;
    logic sda_m_q, sda_s_q, sda_h_q;

    // Synchronizers reset to the idle-bus level so no edge is seen on release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_m_q <= 1'b1;
            scl_s_q <= 1'b1;
            scl_h_q <= 1'b1;
            sda_m_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_h_q <= 1'b1;
        end else begin
            scl_m_q <= scl_in;
            scl_s_q <= scl_m_q;
            scl_h_q <= scl_s_q;
            sda_m_q <= sda_in;
            sda_s_q <= sda_m_q;
            sda_h_q <= sda_s_q;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  = scl_s_q & ~scl_h_q;
    assign scl_fall  = ~scl_s_q & scl_h_q;
    assign bus_start = scl_s_q & sda_h_q & ~sda_s_q;
    assign bus_stop  = scl_s_q & ~sda_h_q & sda_s_q;

    logic [3:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_reg_q, wr_reg_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [7:0] regs_q [256];
    logic       mem_we;
    logic [7:0] mem_wa, mem_wd;

    logic [7:0] byte_in, rd_byte;
    assign byte_in = {shift_q[6:0], sda_s_q};
    assign rd_byte = regs_q[ptr_q];

    // phase_q: in ACK states marks the ack bit as driven; in RD_MACK marks a master ACK
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        mem_wa      = ptr_q;
        mem_wd      = byte_in;
        if (bus_stop) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (bus_start) begin
            state_d  = S_DEVADDR;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_DEVADDR, S_REGADDR, S_WRDATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == S_DEVADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_d = S_ACK_DEV;
                                    rw_d    = byte_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_WAIT_STOP;
                                end
                            end else if (state_q == S_REGADDR) begin
                                ptr_d   = byte_in;
                                state_d = S_ACK_REG;
                            end else begin
                                mem_we      = 1'b1;
                                wr_reg_d    = ptr_q;
                                wr_data_d   = byte_in;
                                wr_strobe_d = 1'b1;
                                ptr_d       = ptr_q + 8'd1;
                                state_d     = S_ACK_WR;
                            end
                        end
                    end
                end
                S_ACK_DEV, S_ACK_REG, S_ACK_WR: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            cnt_d   = 3'd0;
                            phase_d = 1'b0;
                            if (state_q == S_ACK_DEV && rw_q) begin
                                state_d  = S_RDDATA;
                                shift_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = (state_q == S_ACK_DEV) ? S_REGADDR : S_WRDATA;
                            end
                        end
                    end
                end
                S_RDDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = S_RD_MACK;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 3'd1;
                        end
                    end
                end
                S_RD_MACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s_q) begin
                            ptr_d   = ptr_q + 8'd1;
                            phase_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end else if (scl_fall && phase_q) begin
                        state_d  = S_RDDATA;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        cnt_d    = 3'd0;
                        phase_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 8'h00;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_reg_q    <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else if (mem_we) begin
            regs_q[mem_wa] <= mem_wd;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sccb_target_regfile.sv
// tb/tb_sccb_target_regfile.sv - bit-banged SCCB master against a register-file model
`timescale 1ns/1ps
module tb_sccb_target_regfile;
    localparam int Q = 10;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] wr_reg, wr_data;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    sccb_target_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  m_regs [256];
    logic [7:0]  m_ptr;
    logic [15:0] exp_strobes[$];
    logic [15:0] got_strobes[$];
    logic        strobe_prev = 1'b0;
    int          strobe_long = 0;
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_strobe) got_strobes.push_back({wr_reg, wr_data});
        if (wr_strobe && strobe_prev) strobe_long++;
        strobe_prev = wr_strobe;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic wq(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; wq(); scl = 1'b1; wq(); sda_m = 1'b0; wq(); scl = 1'b0; wq();
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; wq(); scl = 1'b1; wq(); sda_m = 1'b1; wq(2);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wq(); scl = 1'b1; wq(2); scl = 1'b0; wq();
        end
        sda_m = 1'b1; wq(); scl = 1'b1; wq(); ack = ~sda_bus; wq(); scl = 1'b0; wq();
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wq(); scl = 1'b1; wq(); b[i] = sda_bus; wq(); scl = 1'b0; wq();
        end
        sda_m = ~master_ack; wq(); scl = 1'b1; wq(2); scl = 1'b0; wq(); sda_m = 1'b1;
    endtask

    // Full write transaction; the model applies SCCB semantics at byte level
    task automatic do_write(input byte_q_t bytes);
        logic ack;
        logic match;
        match = (bytes[0][7:1] == 7'h21) && !bytes[0][0];
        bus_start();
        for (int k = 0; k < bytes.size(); k++) begin
            send_byte(bytes[k], ack);
            chk("ack", ack, match);
            if (k == 0 && match) chk("busy_on", busy, 1);
            if (match && k == 1) m_ptr = bytes[1];
            if (match && k >= 2) begin
                m_regs[m_ptr] = bytes[k];
                exp_strobes.push_back({m_ptr, bytes[k]});
                m_ptr = m_ptr + 8'd1;
            end
        end
        bus_stop();
        chk("busy_end", busy, 0);
    endtask

    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] b;
        bus_start();
        send_byte(8'h43, ack);
        chk("rd_ack", ack, 1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, b);
            chk("rd_data", b, m_regs[m_ptr]);
            if (k < n - 1) m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        chk("rd_oe_rel", sda_oe, 0);
    endtask

    task automatic check_strobes;
        chk("n_strobe", got_strobes.size(), exp_strobes.size());
        while (got_strobes.size() > 0 && exp_strobes.size() > 0)
            chk("strobe", got_strobes.pop_front(), exp_strobes.pop_front());
        got_strobes.delete();
        exp_strobes.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] b, r, d0, d1;
        int         n;
        byte_q_t    q;
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        m_ptr = 8'h00;

        wq(2);
        chk("rst_oe", sda_oe, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        wq(2);

        do_write('{8'h42, 8'h12, 8'h80});
        check_strobes();
        chk("last_reg", wr_reg, 8'h12);
        chk("last_data", wr_data, 8'h80);

        oe_seen = 1'b0; busy_seen = 1'b0;
        do_write('{8'h40, 8'h12, 8'h55});
        chk("bad_oe", oe_seen, 0);
        chk("bad_busy", busy_seen, 0);
        check_strobes();
        do_write('{8'h42, 8'h12});
        do_read(1);

        do_write('{8'h42, 8'h11, 8'h01, 8'h02});
        check_strobes();

        do_write('{8'h42, 8'h6B, 8'h0A});
        check_strobes();
        do_write('{8'h42, 8'h6B});
        do_read(1);

        d0 = 8'($urandom); d1 = 8'($urandom);
        do_write('{8'h42, 8'hFF, d0, d1});
        check_strobes();
        do_write('{8'h42, 8'hFF});
        do_read(2);

        // Reset during the 4th data bit of a write
        bus_start();
        send_byte(8'h42, ack); chk("rw_ack0", ack, 1);
        send_byte(8'h20, ack); chk("rw_ack1", ack, 1);
        b = 8'hA5;
        for (int i = 7; i >= 5; i--) begin
            sda_m = b[i]; wq(); scl = 1'b1; wq(2); scl = 1'b0; wq();
        end
        sda_m = b[4]; wq(); scl = 1'b1; wq();
        reset = 1'b1;
        #1;
        chk("rst_mid_oe", sda_oe, 0);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        m_ptr = 8'h00;
        wq(); scl = 1'b0; wq();
        reset = 1'b0;
        wq();
        bus_stop();
        check_strobes();
        chk("rst_wr_reg2", wr_reg, 0);
        do_write('{8'h42, 8'h05, 8'h77});
        check_strobes();
        do_write('{8'h42, 8'h05});
        do_read(1);
        do_write('{8'h42, 8'h12});
        do_read(1);

        for (int it = 0; it < 8; it++) begin
            r = 8'($urandom);
            n = $urandom_range(1, 3);
            q = '{8'h42, r};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            do_write(q);
            check_strobes();
            if ($urandom_range(0, 2) == 0) begin
                b = {7'($urandom_range(0, 127)), 1'b0};
                if (b[7:1] == 7'h21) b = 8'h44;
                do_write('{b, r, 8'($urandom)});
                check_strobes();
            end
            do_write('{8'h42, r});
            do_read(n);
        end

        chk("strobe_width", strobe_long, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
